// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and RAM signals shared by mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              i_addr_valid;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid;

    logic              d_addr_valid;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              m_cs;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;
    logic [DATA_W-1:0] m_dout;

    // Arbiter side: takes requests and RAM read data, drives responses and RAM issue.
    modport slave (
        input  i_addr_valid, i_addr, d_addr_valid, d_we, d_addr, d_wdata, m_dout,
        output i_data, i_data_valid, d_rdata, d_ready, m_cs, m_we, m_addr, m_din
    );

    // Environment side: pipeline requesters plus the RAM.
    modport master (
        output i_addr_valid, i_addr, d_addr_valid, d_we, d_addr, d_wdata, m_dout,
        input  i_data, i_data_valid, d_rdata, d_ready, m_cs, m_we, m_addr, m_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of one single-port synchronous RAM
module mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   dstreak_q, dstreak_d;
    logic            i_elig, d_elig;
    logic            grant_i, grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
        end
    end

    assign bus.i_data  = bus.m_dout;
    assign bus.d_rdata = bus.m_dout;

    always_comb begin
        state_d          = IDLE;
        dstreak_d        = dstreak_q;
        bus.m_cs         = 1'b0;
        bus.m_we         = 1'b0;
        bus.m_addr       = '0;
        bus.m_din        = '0;
        bus.i_data_valid = 1'b0;
        bus.d_ready      = 1'b0;

        // A port receiving its read response this cycle cannot be granted again.
        i_elig  = bus.i_addr_valid && (state_q != I_WAIT) && !rst;
        d_elig  = bus.d_addr_valid && (state_q != D_WAIT) && !rst;
        grant_i = i_elig && (!d_elig || (dstreak_q == STREAK_MAX));
        grant_d = d_elig && !grant_i;

        if (grant_i) begin
            state_d    = I_WAIT;
            bus.m_cs   = 1'b1;
            bus.m_addr = ADDR_W'(bus.i_addr);
        end else if (grant_d) begin
            state_d    = bus.d_we ? IDLE : D_WAIT;
            bus.m_cs   = 1'b1;
            bus.m_we   = bus.d_we;
            bus.m_addr = ADDR_W'(bus.d_addr);
            bus.m_din  = bus.d_we ? DATA_W'(bus.d_wdata) : '0;
        end

        bus.i_data_valid = (state_q == I_WAIT);
        bus.d_ready      = (state_q == D_WAIT) || (grant_d && bus.d_we);

        // Streak only matters while a fetch is waiting; it resets as soon as fetch is served or gone.
        if (!bus.i_addr_valid || grant_i) begin
            dstreak_d = '0;
        end else if (grant_d && (dstreak_q != STREAK_MAX)) begin
            dstreak_d = dstreak_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a registered RAM model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loaded = 1'b0;
    logic done = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifc ();

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DSTREAK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    logic [63:0] mem [0:127];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < 128; k++) mem[k] <= 64'(k) * 64'h11;
            loaded <= 1'b1;
            ifc.m_dout <= '0;
        end else if (ifc.m_cs) begin
            if (ifc.m_we) mem[ifc.m_addr[9:3]] <= ifc.m_din;
            else          ifc.m_dout <= mem[ifc.m_addr[9:3]];
        end
    end

    typedef struct {
        logic        is_wr;
        logic [63:0] data;
    } dexp_t;

    logic [63:0] iq [$];
    dexp_t       dq [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_d(input logic is_wr, input logic [63:0] data);
        dexp_t e;
        e.is_wr = is_wr;
        e.data  = data;
        dq.push_back(e);
    endtask

    task automatic fetch_rd(input logic [63:0] a, input logic [63:0] e);
        ifc.i_addr_valid = 1'b1;
        ifc.i_addr       = a;
        iq.push_back(e);
        @(negedge clk);
        chk("f_issue", {ifc.m_cs, ifc.m_we, ifc.m_addr, ifc.i_data_valid}, {1'b1, 1'b0, a, 1'b0});
        cyc();
        @(negedge clk);
        chk("f_resp", {ifc.i_data_valid, ifc.m_cs}, {1'b1, 1'b0});
        cyc();
        ifc.i_addr_valid = 1'b0;
    endtask

    task automatic data_wr(input logic [63:0] a, input logic [63:0] w);
        ifc.d_addr_valid = 1'b1;
        ifc.d_we         = 1'b1;
        ifc.d_addr       = a;
        ifc.d_wdata      = w;
        push_d(1'b1, w);
        @(negedge clk);
        chk("w_issue", {ifc.m_cs, ifc.m_we, ifc.m_addr, ifc.d_ready}, {1'b1, 1'b1, a, 1'b1});
        cyc();
        ifc.d_addr_valid = 1'b0;
        ifc.d_we         = 1'b0;
    endtask

    task automatic data_rd(input logic [63:0] a, input logic [63:0] e);
        ifc.d_addr_valid = 1'b1;
        ifc.d_we         = 1'b0;
        ifc.d_addr       = a;
        push_d(1'b0, e);
        @(negedge clk);
        chk("r_issue", {ifc.m_cs, ifc.m_we, ifc.m_addr, ifc.d_ready}, {1'b1, 1'b0, a, 1'b0});
        cyc();
        @(negedge clk);
        chk("r_resp", {ifc.d_ready, ifc.m_cs}, {1'b1, 1'b0});
        cyc();
        ifc.d_addr_valid = 1'b0;
    endtask

    initial begin
        dexp_t e;
        int    w;
        int    pat [7] = '{0, 0, 0, 0, 1, 0, 0};

        ifc.i_addr_valid = 1'b0;
        ifc.i_addr       = '0;
        ifc.d_addr_valid = 1'b1;
        ifc.d_we         = 1'b1;
        ifc.d_addr       = 64'h40;
        ifc.d_wdata      = 64'h1234;

        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    if (ifc.i_data_valid) begin
                        if (iq.size() == 0) chk("i_unexpected", 1, 0);
                        else chk("i_data", ifc.i_data, iq.pop_front());
                    end
                    if (ifc.d_ready) begin
                        if (dq.size() == 0) chk("d_unexpected", 1, 0);
                        else begin
                            e = dq.pop_front();
                            if (e.is_wr) chk("d_wr_din", ifc.m_din, e.data);
                            else         chk("d_rdata", ifc.d_rdata, e.data);
                        end
                    end
                end
            end
            begin
                // Reset with a write request present: nothing may reach the RAM.
                repeat (2) begin
                    @(negedge clk);
                    chk("reset_outs", {ifc.m_cs, ifc.m_we, ifc.i_data_valid, ifc.d_ready, ifc.m_addr, ifc.m_din},
                        {4'b0000, 64'h0, 64'h0});
                end
                cyc();
                rst = 1'b0;
                ifc.d_addr_valid = 1'b0;
                ifc.d_we         = 1'b0;

                for (int i = 0; i < 3; i++) fetch_rd(64'(8 * i), 64'(i) * 64'h11);

                data_wr(64'h40, 64'hDEADBEEF);
                data_rd(64'h40, 64'hDEADBEEF);

                // Both ports reading continuously: strict alternation starting with data.
                ifc.i_addr_valid = 1'b1; ifc.i_addr = 64'h18;
                ifc.d_addr_valid = 1'b1; ifc.d_we = 1'b0; ifc.d_addr = 64'h20;
                for (int k = 0; k < 6; k++) begin
                    if (k % 2 == 0) push_d(1'b0, 64'h44);
                    else            iq.push_back(64'h33);
                    @(negedge clk);
                    chk("alt_grant", ifc.m_addr, (k % 2 == 0) ? 64'h20 : 64'h18);
                    chk("alt_streak", 128'(dut.dstreak_q <= 1), 128'(1));
                    cyc();
                end
                ifc.d_addr_valid = 1'b0;
                @(negedge clk);
                chk("alt_tail", {ifc.m_cs, ifc.i_data_valid}, {1'b0, 1'b1});
                cyc();
                ifc.i_addr_valid = 1'b0;

                // Continuous writes with fetch pending: four writes, one fetch, writes resume.
                w = 0;
                ifc.i_addr_valid = 1'b1; ifc.i_addr = 64'h28;
                ifc.d_addr_valid = 1'b1; ifc.d_we = 1'b1;
                for (int n = 0; n < 7; n++) begin
                    ifc.d_addr  = 64'h60 + 64'(8 * w);
                    ifc.d_wdata = 64'h1000 + 64'(w);
                    if (n == 6) ifc.i_addr_valid = 1'b0;
                    if (pat[n] == 0) push_d(1'b1, 64'h1000 + 64'(w));
                    else             iq.push_back(64'h55);
                    @(negedge clk);
                    if (pat[n] == 0) begin
                        chk("streak_wr", {ifc.m_we, ifc.m_addr, ifc.d_ready}, {1'b1, 64'h60 + 64'(8 * w), 1'b1});
                        w++;
                    end else begin
                        chk("streak_fetch", {ifc.m_we, ifc.m_addr, ifc.d_ready}, {1'b0, 64'h28, 1'b0});
                    end
                    cyc();
                end
                ifc.d_addr_valid = 1'b0; ifc.d_we = 1'b0;

                // Fetch response coinciding with a write issue.
                ifc.i_addr_valid = 1'b1; ifc.i_addr = 64'h08;
                iq.push_back(64'h11);
                cyc();
                ifc.d_addr_valid = 1'b1; ifc.d_we = 1'b1; ifc.d_addr = 64'h48; ifc.d_wdata = 64'hCAFE;
                push_d(1'b1, 64'hCAFE);
                @(negedge clk);
                chk("overlap", {ifc.i_data_valid, ifc.d_ready, ifc.m_we, ifc.m_addr}, {3'b111, 64'h48});
                cyc();
                ifc.i_addr_valid = 1'b0; ifc.d_addr_valid = 1'b0; ifc.d_we = 1'b0;

                // Reset during D_WAIT discards the read; the held request is reissued afterwards.
                ifc.d_addr_valid = 1'b1; ifc.d_we = 1'b0; ifc.d_addr = 64'h10;
                @(negedge clk);
                chk("rmr_issue", {ifc.m_cs, ifc.m_addr}, {1'b1, 64'h10});
                cyc();
                rst = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk("rmr_held", {ifc.d_ready, ifc.m_cs, ifc.m_addr}, {2'b00, 64'h0});
                    cyc();
                end
                rst = 1'b0;
                push_d(1'b0, 64'h22);
                @(negedge clk);
                chk("rmr_reissue", {ifc.m_cs, ifc.m_addr, ifc.d_ready}, {1'b1, 64'h10, 1'b0});
                cyc();
                @(negedge clk);
                chk("rmr_done", ifc.d_ready, 1);
                cyc();
                ifc.d_addr_valid = 1'b0;

                repeat (10) begin
                    @(negedge clk);
                    chk("idle", {ifc.m_cs, ifc.m_we, ifc.i_data_valid, ifc.d_ready, 128'(dut.dstreak_q)},
                        {4'b0000, 128'h0});
                end

                chk("iq_empty", iq.size(), 0);
                chk("dq_empty", dq.size(), 0);
                done = 1'b1;
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
